// File: rtl/seg7_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pkg : shared 7-segment constants, scan FSM encoding, encode helper
// Revision : 1.0
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int SEG7_STABLE_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  // Active-high segment patterns, bit0=a .. bit6=g, indexed by nibble value.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] value);
    return SEG7_TABLE[value];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_bin.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_to_bin : combinational 7-segment pattern to nibble decoder with hit flag
// Revision    : 1.0
// ---------------------------------------------------------------------------
module seg7_to_bin
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       hit
);

  always_comb begin
    value = 4'd0;
    hit   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_TABLE[i]) begin
        value = 4'(i);
        hit   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_decoder : recovers per-digit nibbles from a multiplexed 7-seg scan
// Revision          : 1.0
// ---------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = SEG7_STABLE_CYCLES_DEFAULT,
  parameter int DIGITS        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     err,
  output logic                  new_data,
  output logic                  frame_done
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [6:0]          seg_s_q, seg_s_d, seg_p_q, seg_p_d;
  logic [DIGITS-1:0]   an_s_q, an_s_d, an_p_q, an_p_d;
  logic [7:0]          cnt_q, cnt_d;
  scan_state_e         state_q, state_d;
  logic                cap_q, cap_d;
  logic [6:0]          cap_seg_q, cap_seg_d;
  logic [DIGITS-1:0]   cap_an_q, cap_an_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                new_data_q, new_data_d;
  logic                frame_done_q, frame_done_d;

  logic                w_change;
  logic                w_onehot;
  logic [DIGITS-1:0]   w_seen_or;
  logic [3:0]          w_dec_value;
  logic                w_dec_hit;

  seg7_to_bin u_seg7_to_bin (
    .seg   (cap_seg_q),
    .value (w_dec_value),
    .hit   (w_dec_hit)
  );

  always_comb begin
    seg_s_d      = seg_in;
    an_s_d       = an_in;
    seg_p_d      = seg_s_q;
    an_p_d       = an_s_q;
    state_d      = state_q;
    cap_d        = 1'b0;
    cap_seg_d    = cap_seg_q;
    cap_an_d     = cap_an_q;
    digits_d     = digits_q;
    valid_d      = valid_q;
    err_d        = err_q;
    seen_d       = seen_q;
    new_data_d   = 1'b0;
    frame_done_d = 1'b0;
    w_seen_or    = seen_q | cap_an_q;

    w_change = {an_s_q, seg_s_q} != {an_p_q, seg_p_q};
    w_onehot = $onehot(an_s_q);

    if (w_change)                cnt_d = 8'd0;
    else if (cnt_q >= STABLE_MAX) cnt_d = STABLE_MAX;
    else                          cnt_d = cnt_q + 8'd1;

    // A change always clears the counter, so reaching the threshold implies
    // the sample has been steady; this also drops captures on an an_in change.
    case (state_q)
      ST_IDLE: begin
        if (w_onehot) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!w_onehot) begin
          state_d = ST_IDLE;
        end else if (cnt_d == STABLE_MAX) begin
          state_d   = ST_HOLD;
          cap_d     = 1'b1;
          cap_seg_d = seg_s_q;
          cap_an_d  = an_s_q;
        end
      end
      ST_HOLD: begin
        if (w_change) state_d = w_onehot ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Apply the capture registered on the previous edge.
    if (cap_q) begin
      new_data_d = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (cap_an_q[i]) begin
          if (w_dec_hit) begin
            digits_d[4*i +: 4] = w_dec_value;
            valid_d[i]         = 1'b1;
            err_d[i]           = 1'b0;
          end else begin
            valid_d[i]         = 1'b0;
            err_d[i]           = 1'b1;
          end
        end
      end
      if (&w_seen_or) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d       = w_seen_or;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s_q      <= '0;
      an_s_q       <= '0;
      seg_p_q      <= '0;
      an_p_q       <= '0;
      cnt_q        <= '0;
      state_q      <= ST_IDLE;
      cap_q        <= 1'b0;
      cap_seg_q    <= '0;
      cap_an_q     <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      new_data_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      seg_s_q      <= seg_s_d;
      an_s_q       <= an_s_d;
      seg_p_q      <= seg_p_d;
      an_p_q       <= an_p_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      cap_q        <= cap_d;
      cap_seg_q    <= cap_seg_d;
      cap_an_q     <= cap_an_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      seen_q       <= seen_d;
      new_data_q   <= new_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digits     = digits_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign new_data   = new_data_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder : directed self-checking bench for seg7_scan_decoder
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  localparam int S = 4;
  localparam int D = 4;

  logic           clk;
  logic           rst;
  logic [6:0]     seg_in;
  logic [D-1:0]   an_in;
  logic [4*D-1:0] digits;
  logic [D-1:0]   valid;
  logic [D-1:0]   err;
  logic           new_data;
  logic           frame_done;

  int n_checks;
  int n_fail;
  int nd_cnt;
  int fd_cnt;
  int nd_at_fd;
  int pulse_k;

  seg7_scan_decoder #(
    .STABLE_CYCLES (S),
    .DIGITS        (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .digits     (digits),
    .valid      (valid),
    .err        (err),
    .new_data   (new_data),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference encoder standing in for the existing bin_to_7seg.
  function automatic logic [6:0] bin_to_7seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (new_data) nd_cnt++;
    if (frame_done) begin
      fd_cnt++;
      nd_at_fd = nd_cnt;
    end
  endtask

  task automatic clear_counts();
    nd_cnt   = 0;
    fd_cnt   = 0;
    nd_at_fd = 0;
  endtask

  task automatic hold(input logic [D-1:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    an_in  = '0;
    seg_in = '0;
    step();
    rst    = 1'b0;
  endtask

  logic [6:0] frame_pats [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_counts();
    rst    = 1'b1;
    an_in  = '0;
    seg_in = '0;
    frame_pats = '{7'h06, 7'h4F, 7'h66, 7'h6D};

    // Reset state
    repeat (2) step();
    check_eq("rst_digits", digits, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_new_data", new_data, 0);
    check_eq("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    clear_counts();
    repeat (4) step();
    check_eq("idle_no_pulse", nd_cnt, 0);

    // Single capture latency: pulse S+2 edges after the first sampling edge
    clear_counts();
    an_in   = 4'b0001;
    seg_in  = 7'h5B;
    step();
    pulse_k = -1;
    for (int k = 1; k <= S + 4; k++) begin
      step();
      if (new_data && pulse_k < 0) pulse_k = k;
    end
    check_eq("lat_edge", pulse_k, S + 2);
    check_eq("lat_pulses", nd_cnt, 1);
    check_eq("lat_digit0", digits[3:0], 4'h2);
    check_eq("lat_valid", valid, 4'b0001);
    check_eq("lat_err", err, 4'b0000);

    // Full frame over positions 0..3
    do_reset();
    clear_counts();
    for (int p = 0; p < 4; p++) hold(4'(1 << p), frame_pats[p], 6);
    repeat (4) step();
    check_eq("frame_digits", digits, 16'h5431);
    check_eq("frame_valid", valid, 4'b1111);
    check_eq("frame_nd", nd_cnt, 4);
    check_eq("frame_fd", fd_cnt, 1);
    check_eq("frame_fd_with_4th", nd_at_fd, 4);

    // Unrecognised pattern at position 1
    clear_counts();
    hold(4'b0010, 7'h55, 9);
    check_eq("bad_err", err, 4'b0010);
    check_eq("bad_valid", valid, 4'b1101);
    check_eq("bad_digits", digits, 16'h5431);
    check_eq("bad_nd", nd_cnt, 1);
    check_eq("bad_no_fd", fd_cnt, 0);

    // Unstable segments and non-one-hot select never capture
    clear_counts();
    for (int t = 0; t < 10; t++) hold(4'b0001, t[0] ? 7'h06 : 7'h3F, 2);
    check_eq("toggle_no_nd", nd_cnt, 0);
    hold(4'b0011, 7'h3F, 10);
    check_eq("multi_an_no_nd", nd_cnt, 0);
    check_eq("noise_valid", valid, 4'b1101);

    // Reset after three positions discards the partial frame
    do_reset();
    clear_counts();
    hold(4'b0001, 7'h3F, 6);
    hold(4'b0010, 7'h06, 6);
    hold(4'b0100, 7'h5B, 8);
    check_eq("partial_nd", nd_cnt, 3);
    rst    = 1'b1;
    an_in  = 4'b1000;
    seg_in = 7'h7D;
    step();
    rst = 1'b0;
    clear_counts();
    step();
    check_eq("post_rst_nd", new_data, 0);
    check_eq("post_rst_valid", valid, 0);
    repeat (7) step();
    check_eq("post_rst_cap_valid", valid, 4'b1000);
    check_eq("post_rst_cap_digit", digits[15:12], 4'h6);
    check_eq("post_rst_no_fd", fd_cnt, 0);

    // Encoder-driven sweep of all nibble values
    do_reset();
    clear_counts();
    for (int v = 0; v < 16; v++) begin
      hold(4'(1 << (v % 4)), bin_to_7seg(4'(v)), 7);
      check_eq($sformatf("enc_val_%0d", v), digits[4*(v%4) +: 4], v);
    end
    check_eq("enc_nd", nd_cnt, 16);
    check_eq("enc_fd", fd_cnt, 4);
    check_eq("enc_valid", valid, 4'b1111);
    check_eq("enc_err", err, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (range 2..255): consecutive identical samples required before a capture.
REQ-002 SHALL have parameter DIGITS, default 4: number of scanned digit positions.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port seg_in, input, 7 bits: segment pattern, active-high, bit0=a through bit6=g.
REQ-006 SHALL have port an_in, input, DIGITS bits: digit select, active-high, one-hot when valid.
REQ-007 SHALL have port digits, output, 4*DIGITS bits: decoded nibble per position, position i at bits [4i+3:4i].
REQ-008 SHALL have port valid, output, DIGITS bits: position holds a decoded value.
REQ-009 SHALL have port err, output, DIGITS bits: last capture at that position was an unrecognised pattern.
REQ-010 SHALL have port new_data, output, 1 bit: one-cycle pulse after any capture.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse after every position has been captured since the previous pulse.

Function
REQ-012 SHALL register seg_in and an_in once (sample stage) before any comparison; no combinational input-to-output path.
REQ-013 SHALL keep an 8-bit stability counter: cleared when the sampled {an,seg} differs from the previous sample, otherwise incremented, saturating at STABLE_CYCLES.
REQ-014 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-015 IDLE: sampled an not one-hot (zero or multiple bits); no capture; go to SETTLE when an becomes one-hot.
REQ-016 SETTLE: on the edge where the counter reaches STABLE_CYCLES, capture and go to HOLD; any input change restarts the count in SETTLE; non-one-hot an goes to IDLE.
REQ-017 HOLD: no further capture of an unchanged input; any change goes to SETTLE (one-hot an) or IDLE (otherwise).
REQ-018 SHALL decode seg[6:0] hex values 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 to nibbles 0..F respectively.
REQ-019 On a recognised capture at position i: digits[i] updates, valid[i]=1, err[i]=0.
REQ-020 On an unrecognised capture (including 0x00): digits[i] unchanged, valid[i]=0, err[i]=1.
REQ-021 Captured outputs and new_data SHALL appear on the edge after the capture edge; total latency from first stable input edge to outputs is STABLE_CYCLES+2 cycles.
REQ-022 SHALL track a DIGITS-bit seen mask set on each capture (recognised or not); when the mask becomes all-ones, pulse frame_done together with that capture's new_data, then clear the mask.
REQ-023 A repeated capture of an already-seen position within a frame SHALL update outputs but not set frame_done.
REQ-024 An an_in change on the same edge the counter would reach STABLE_CYCLES SHALL suppress that capture.

Reset
REQ-025 While rst=1 on an edge: digits=0, valid=0, err=0, new_data=0, frame_done=0, seen mask=0, counter=0, sample registers=0, state=IDLE.
REQ-026 Reset mid-SETTLE or mid-frame SHALL discard partial progress; no pulse is emitted in the cycle after reset is released.

Structure
REQ-027 Decode table constants, FSM state encoding and the default STABLE_CYCLES SHALL live in a shared package, seg7_pkg, reusable by the existing binary-to-7-segment encoder.
REQ-028 Pattern decode SHALL be a combinational sub-module seg7_to_bin (7-bit in, 4-bit value plus 1-bit hit out).

Verification
REQ-029 Drive an_in=0001, seg_in=0x5B for 6 cycles -> digits[3:0]=2, valid=0001, new_data one pulse, exactly STABLE_CYCLES+2 cycles after first drive.
REQ-030 Scan positions 0..3 with 0x06,0x4F,0x66,0x6D, 6 cycles each -> digits=0x5431, valid=1111, frame_done pulses once, coincident with the fourth new_data.
REQ-031 an_in=0010, seg_in=0x55 for 6 cycles -> err=0010, valid[1]=0, digits[7:4] unchanged.
REQ-032 an_in=0001, seg_in toggling 0x3F/0x06 every 2 cycles for 20 cycles -> no new_data; an_in=0011 for 10 cycles -> no new_data.
REQ-033 Assert rst for 1 cycle after 3 positions of a frame; then capture the 4th position -> valid shows only that bit, frame_done does not pulse.
REQ-034 Compare against an encoder-driven loop (bin_to_7seg output feeding seg_in) for all values 0..F -> decoded nibble equals the input value at every position.
